// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the fewcore hazard/forwarding scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fewcore_pkg;

    // Default register address width. Scoreboard entries store rd at this width.
    localparam int REG_AW_DEF = 5;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // One in-flight writer slot.
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  is_load;
    } sb_entry_t;

    // Width of a select that can encode the register file plus one code per stage.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// Per-operand priority encoder: finds the youngest in-flight writer of rs.
// Latency: purely combinational.
// Backpressure: none; not_ready tells the parent to stall on a young load.
//
// Ports:
//   entries   : scoreboard contents, index 0 = youngest (execute output)
//   en        : decode slot valid; no forwarding is requested when low
//   rs        : source register to look up; register 0 never matches
//   sel       : 0 = register file, k+1 = forward from stage k
//   not_ready : the winning writer is a load whose data is not yet forwardable
module fwd_match
    import fewcore_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = sel_width(DEPTH),
    parameter int REG_AW   = REG_AW_DEF
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic                  en,
    input  logic [REG_AW-1:0]     rs,
    output logic [SEL_W-1:0]      sel,
    output logic                  not_ready
);

    // Scan from oldest to youngest so the youngest match is the last to
    // assign and therefore wins.
    always_comb begin
        sel       = SEL_W'(FWD_SEL_RF);
        not_ready = 1'b0;
        if (en && (rs != '0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (entries[k].valid && (entries[k].rd == REG_AW_DEF'(rs))) begin
                    sel       = SEL_W'(k + 1);
                    not_ready = entries[k].is_load && (k < LOAD_LAT);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding unit: shift-register scoreboard of in-flight writers beside decode.
// Latency: selects, stall and flush are combinational; scoreboard advances every clk.
// Backpressure: stall holds fetch/decode and inserts a bubble; flush kills the decode slot.
//
// Ports:
//   clk, reset (async, active-low)
//   id_valid/id_rs1/id_rs2/id_rd/id_we/id_is_load : decode-slot instruction
//   ex_branch_taken : taken branch resolved in execute this cycle
//   stall, flush, fwd_sel_rs1, fwd_sel_rs2, inflight : hazard outputs
//   stall_cnt, flush_cnt : saturating event counters, present only when
//                          FWD_SCOREBOARD_STATS_EN is defined
// REG_AW must not exceed fewcore_pkg::REG_AW_DEF (width of the stored rd).
module fwd_scoreboard
    import fewcore_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SEL_W     = sel_width(FWD_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_AW-1:0]    id_rs1,
    input  logic [REG_AW-1:0]    id_rs2,
    input  logic [REG_AW-1:0]    id_rd,
    input  logic                 id_we,
    input  logic                 id_is_load,
    input  logic                 ex_branch_taken,
    output logic                 stall,
    output logic                 flush,
    output logic [SEL_W-1:0]     fwd_sel_rs1,
    output logic [SEL_W-1:0]     fwd_sel_rs2,
    output logic [FWD_DEPTH-1:0] inflight
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    sb_entry_t [FWD_DEPTH-1:0] sb;
    sb_entry_t                 new_entry;
    logic                      nr_rs1;
    logic                      nr_rs2;
    logic                      issue;

    fwd_match #(
        .DEPTH    (FWD_DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .SEL_W    (SEL_W),
        .REG_AW   (REG_AW)
    ) u_match_rs1 (
        .entries   (sb),
        .en        (id_valid),
        .rs        (id_rs1),
        .sel       (fwd_sel_rs1),
        .not_ready (nr_rs1)
    );

    fwd_match #(
        .DEPTH    (FWD_DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .SEL_W    (SEL_W),
        .REG_AW   (REG_AW)
    ) u_match_rs2 (
        .entries   (sb),
        .en        (id_valid),
        .rs        (id_rs2),
        .sel       (fwd_sel_rs2),
        .not_ready (nr_rs2)
    );

    // Flush is gated by reset so every output reads zero while reset is held,
    // even if execute is still presenting a stale taken branch.
    assign flush = ex_branch_taken & reset;
    assign stall = id_valid & (nr_rs1 | nr_rs2) & ~flush;
    assign issue = id_valid & ~stall & ~flush;

    // Anything that does not issue a real writer enters as an all-zero bubble.
    always_comb begin
        new_entry = '0;
        if (issue && id_we && (id_rd != '0)) begin
            new_entry.valid   = 1'b1;
            new_entry.rd      = REG_AW_DEF'(id_rd);
            new_entry.is_load = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb <= '0;
        end else begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                sb[k] <= sb[k-1];
            end
            sb[0] <= new_entry;
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            inflight[k] = sb[k].valid;
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random traffic.
// Latency: outputs compared every negedge against a behavioural model.
// Backpressure: model decides stall/flush itself and tracks what actually issues.
module tb_fwd_scoreboard;

    localparam int AW = 5;
    localparam int D  = 2;
    localparam int LL = 1;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic [AW-1:0] id_rd = '0;
    logic          id_we = 1'b0;
    logic          id_is_load = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          stall;
    logic          flush;
    logic [SW-1:0] fwd_sel_rs1;
    logic [SW-1:0] fwd_sel_rs2;
    logic [D-1:0]  inflight;
`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .REG_AW    (AW),
        .FWD_DEPTH (D),
        .LOAD_LAT  (LL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_we           (id_we),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush           (flush),
        .fwd_sel_rs1     (fwd_sel_rs1),
        .fwd_sel_rs2     (fwd_sel_rs2),
        .inflight        (inflight)
`ifdef FWD_SCOREBOARD_STATS_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Writers issued in the last D cycles, index = age in cycles (0 = last cycle).
    logic          m_valid [D] = '{default: 1'b0};
    logic [AW-1:0] m_rd    [D] = '{default: '0};
    logic          m_load  [D] = '{default: 1'b0};
    int            m_stall_cnt = 0;
    int            m_flush_cnt = 0;

    // Youngest writer of rs; a load issued fewer than LL cycles ago is not ready.
    function automatic void lookup(input logic [AW-1:0] rs, output logic [SW-1:0] sel,
                                   output logic nr);
        bit found = 0;
        sel = '0;
        nr  = 1'b0;
        if (id_valid && rs != 0) begin
            for (int age = 0; age < D; age++) begin
                if (!found && m_valid[age] && m_rd[age] == rs) begin
                    found = 1;
                    sel   = SW'(age + 1);
                    nr    = m_load[age] && (age < LL);
                end
            end
        end
    endfunction

    function automatic void model_eval(output logic st, output logic fl,
                                       output logic [SW-1:0] s1, output logic [SW-1:0] s2,
                                       output logic [D-1:0] inf);
        logic nr1, nr2;
        lookup(id_rs1, s1, nr1);
        lookup(id_rs2, s2, nr2);
        fl = ex_branch_taken && reset;
        st = id_valid && (nr1 || nr2) && !fl;
        for (int a = 0; a < D; a++) inf[a] = m_valid[a];
        if (!reset) begin
            st = 0; fl = 0; s1 = '0; s2 = '0; inf = '0;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        logic st, fl;
        logic [SW-1:0] s1, s2;
        logic [D-1:0] inf;
        if (!reset) begin
            for (int a = 0; a < D; a++) m_valid[a] = 1'b0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            model_eval(st, fl, s1, s2, inf);
            if (st) m_stall_cnt++;
            if (fl) m_flush_cnt++;
            for (int a = D - 1; a > 0; a--) begin
                m_valid[a] = m_valid[a-1];
                m_rd[a]    = m_rd[a-1];
                m_load[a]  = m_load[a-1];
            end
            m_valid[0] = id_valid && !st && !fl && id_we && (id_rd != 0);
            m_rd[0]    = id_rd;
            m_load[0]  = id_is_load;
        end
    end

    // Compare process: inputs are stable at negedge.
    always @(negedge clk) begin
        logic st, fl;
        logic [SW-1:0] s1, s2;
        logic [D-1:0] inf;
        model_eval(st, fl, s1, s2, inf);
        chk("cmp_stall",    32'(stall),       32'(st));
        chk("cmp_flush",    32'(flush),       32'(fl));
        chk("cmp_sel_rs1",  32'(fwd_sel_rs1), 32'(s1));
        chk("cmp_sel_rs2",  32'(fwd_sel_rs2), 32'(s2));
        chk("cmp_inflight", 32'(inflight),    32'(inf));
`ifdef FWD_SCOREBOARD_STATS_EN
        chk("cmp_stall_cnt", stall_cnt, 32'(m_stall_cnt));
        chk("cmp_flush_cnt", flush_cnt, 32'(m_flush_cnt));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] rd, input logic we, input logic ld,
                         input logic br);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_we = we; id_is_load = ld; ex_branch_taken = br;
        #1;
    endtask

    task automatic idle2();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state, with a taken branch presented to show flush is masked.
        ex_branch_taken = 1'b1;
        #2;
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_stall",    32'(stall),    32'h0);
        chk("rst_flush",    32'(flush),    32'h0);
        chk("rst_sel_rs1",  32'(fwd_sel_rs1), 32'h0);
        ex_branch_taken = 1'b0;
        #10;
        reset = 1'b1;

        // ALU dependence on x5.
        drive(1, 0, 0, 5, 1, 0, 0);
        chk("alu_first_stall", 32'(stall), 32'h0);
        drive(1, 5, 0, 6, 1, 0, 0);
        chk("alu_sel_stage0", 32'(fwd_sel_rs1), 32'h1);
        chk("alu_no_stall",   32'(stall),       32'h0);
        drive(1, 5, 0, 0, 0, 0, 0);
        chk("alu_sel_stage1", 32'(fwd_sel_rs1), 32'h2);
        idle2();
        chk("drained", 32'(inflight), 32'h0);

        // Load-use on x7: one stall cycle, then forward from stage 1.
        drive(1, 0, 0, 7, 1, 1, 0);
        drive(1, 0, 7, 8, 1, 0, 0);
        chk("lu_stall",    32'(stall),       32'h1);
        chk("lu_sel_s0",   32'(fwd_sel_rs2), 32'h1);
        chk("lu_inflt_01", 32'(inflight),    32'h1);
        drive(1, 0, 7, 8, 1, 0, 0);
        chk("lu_unstall",  32'(stall),       32'h0);
        chk("lu_sel_s1",   32'(fwd_sel_rs2), 32'h2);
        chk("lu_inflt_10", 32'(inflight),    32'h2);
        idle2();

        // x0 never tracked; youngest of two x3 writers wins.
        drive(1, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 3, 1, 0, 0);
        chk("x0_sel",      32'(fwd_sel_rs1), 32'h0);
        chk("x0_inflight", 32'(inflight),    32'h0);
        drive(1, 0, 0, 3, 1, 0, 0);
        drive(1, 3, 3, 0, 0, 0, 0);
        chk("prio_rs1",     32'(fwd_sel_rs1), 32'h1);
        chk("prio_rs2",     32'(fwd_sel_rs2), 32'h1);
        chk("prio_inflight", 32'(inflight),   32'h3);
        idle2();

        // Flush overrides a load-use stall; killed instruction never enters.
        drive(1, 0, 0, 9, 1, 1, 0);
        drive(1, 9, 0, 10, 1, 0, 1);
        chk("fl_flush", 32'(flush), 32'h1);
        chk("fl_stall", 32'(stall), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("fl_inflight", 32'(inflight), 32'h2);
        idle2();

        // Async reset mid-stream.
        drive(1, 0, 0, 1, 1, 0, 0);
        drive(1, 0, 0, 2, 1, 0, 0);
        drive(1, 2, 1, 3, 1, 0, 0);
        chk("ar_sel_rs1",  32'(fwd_sel_rs1), 32'h1);
        chk("ar_sel_rs2",  32'(fwd_sel_rs2), 32'h2);
        chk("ar_inflight", 32'(inflight),    32'h3);
        ex_branch_taken = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("ar_inflight0", 32'(inflight),    32'h0);
        chk("ar_stall0",    32'(stall),       32'h0);
        chk("ar_flush0",    32'(flush),       32'h0);
        chk("ar_sel1_0",    32'(fwd_sel_rs1), 32'h0);
        chk("ar_sel2_0",    32'(fwd_sel_rs2), 32'h0);
        #4;
        ex_branch_taken = 1'b0;
        id_valid = 1'b0;
        reset = 1'b1;

        // Random traffic over a small register range to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), 1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
        end

        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
